// File: rtl/wimpy_wb_pkg.sv
// Shared types and sizes for the register-file writeback path.
package wimpy_wb_pkg;

  localparam int unsigned DATA_W   = 16;
  localparam int unsigned ADDR_W   = 4;
  localparam int unsigned NUM_REGS = 16;

  typedef struct packed {
    logic [ADDR_W-1:0] dest;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Dual-push / single-pop circular buffer of writeback entries.
// Push A is always the older of two same-cycle pushes.
module wb_fifo
  import wimpy_wb_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PtrW = $clog2(DEPTH),
  localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              pushA,
  input  wb_entry_t         entryA,
  input  logic              pushB,
  input  wb_entry_t         entryB,
  input  logic              pop,
  output wb_entry_t         head,
  output logic [CntW-1:0]   count,
  output logic [ADDR_W-1:0] slotDest [DEPTH],
  output logic [DEPTH-1:0]  slotValid
);

  wb_entry_t       mem [DEPTH];
  logic [PtrW-1:0] wrPtr;
  logic [PtrW-1:0] rdPtr;
  logic [PtrW-1:0] wrPtrB;

  // B lands behind A when both push in the same cycle.
  assign wrPtrB = pushA ? wrPtr + 1'b1 : wrPtr;
  assign head   = mem[rdPtr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else if (flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      wrPtr <= wrPtr + PtrW'(pushA) + PtrW'(pushB);
      rdPtr <= rdPtr + PtrW'(pop);
      count <= count + CntW'(pushA) + CntW'(pushB) - CntW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!flush) begin
      if (pushA) mem[wrPtr] <= entryA;
      if (pushB) mem[wrPtrB] <= entryB;
    end
  end

  // A slot is live when its distance from the read pointer is below count.
  always_comb begin
    for (int unsigned s = 0; s < DEPTH; s++) begin
      slotDest[s]  = mem[s].dest;
      slotValid[s] = CntW'(PtrW'(PtrW'(s) - rdPtr)) < count;
    end
  end

endmodule

// File: rtl/reg_writeback_queue.sv
// Write-side master of the register file: buffers ALU and load results and
// issues one write per cycle, exposing per-register pending-write bits.
module reg_writeback_queue #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              memValid,
  output logic                              memReady,
  input  logic [ADDR_W-1:0]                 memDest,
  input  logic [DATA_W-1:0]                 memData,
  input  logic                              aluValid,
  output logic                              aluReady,
  input  logic [ADDR_W-1:0]                 aluDest,
  input  logic [DATA_W-1:0]                 aluData,
  input  logic                              wbEnable,
  input  logic                              flush,
  output logic                              rfRegWrite,
  output logic [DATA_W-1:0]                 rfWriteData,
  output logic [ADDR_W-1:0]                 rfRd,
  input  logic [ADDR_W-1:0]                 qRs,
  input  logic [ADDR_W-1:0]                 qRt,
  output logic                              rsBusy,
  output logic                              rtBusy,
  output logic [wimpy_wb_pkg::NUM_REGS-1:0] busyVec
);
  import wimpy_wb_pkg::*;

  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [CntW-1:0] Full       = CntW'(DEPTH);
  localparam logic [CntW-1:0] AlmostFull = CntW'(DEPTH - 1);

  logic [CntW-1:0]   count;
  wb_entry_t         head;
  wb_entry_t         memEntry;
  wb_entry_t         aluEntry;
  logic [ADDR_W-1:0] slotDest [DEPTH];
  logic [DEPTH-1:0]  slotValid;
  logic              memFire;
  logic              aluFire;
  logic              pop;

  // Readies look only at registered occupancy; ALU needs room for a same-cycle load too.
  assign memReady = !flush && (count < Full);
  assign aluReady = !flush && (count < AlmostFull);
  assign memFire  = memValid && memReady;
  assign aluFire  = aluValid && aluReady;
  assign pop      = (count != '0) && wbEnable && !flush;

  assign memEntry = '{dest: memDest, data: memData};
  assign aluEntry = '{dest: aluDest, data: aluData};

  wb_fifo #(
    .DEPTH(DEPTH)
  ) uFifo (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .pushA    (memFire),
    .entryA   (memEntry),
    .pushB    (aluFire),
    .entryB   (aluEntry),
    .pop      (pop),
    .head     (head),
    .count    (count),
    .slotDest (slotDest),
    .slotValid(slotValid)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rfRegWrite  <= 1'b0;
      rfRd        <= '0;
      rfWriteData <= '0;
    end else begin
      rfRegWrite <= pop;
      if (pop) begin
        rfRd        <= head.dest;
        rfWriteData <= head.data;
      end
    end
  end

  // The issuing output stage still counts as pending until the register file captures it.
  always_comb begin
    busyVec = '0;
    for (int unsigned s = 0; s < DEPTH; s++) begin
      if (slotValid[s]) busyVec[slotDest[s]] = 1'b1;
    end
    if (rfRegWrite) busyVec[rfRd] = 1'b1;
  end

  assign rsBusy = busyVec[qRs];
  assign rtBusy = busyVec[qRt];

endmodule

// File: tb/tb_reg_writeback_queue.sv
// Bench for reg_writeback_queue: directed vector table, reset sequence and
// randomized traffic checked against a queue-based reference model.
module tb_reg_writeback_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        memValid, memReady, aluValid, aluReady;
  logic [3:0]  memDest, aluDest, rfRd, qRs, qRt;
  logic [15:0] memData, aluData, rfWriteData, busyVec;
  logic        wbEnable, flush, rfRegWrite, rsBusy, rtBusy;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  reg_writeback_queue #(
    .DEPTH (DEPTH),
    .DATA_W(16),
    .ADDR_W(4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .memValid   (memValid),
    .memReady   (memReady),
    .memDest    (memDest),
    .memData    (memData),
    .aluValid   (aluValid),
    .aluReady   (aluReady),
    .aluDest    (aluDest),
    .aluData    (aluData),
    .wbEnable   (wbEnable),
    .flush      (flush),
    .rfRegWrite (rfRegWrite),
    .rfWriteData(rfWriteData),
    .rfRd       (rfRd),
    .qRs        (qRs),
    .qRt        (qRt),
    .rsBusy     (rsBusy),
    .rtBusy     (rtBusy),
    .busyVec    (busyVec)
  );

  typedef struct packed {
    logic [3:0]  dest;
    logic [15:0] data;
  } ent_t;

  typedef struct {
    logic mv; logic [3:0] md; logic [15:0] mdat;
    logic av; logic [3:0] ad; logic [15:0] adat;
    logic wb; logic fl;
    logic eMr; logic eAr;
    logic eWr; logic [3:0] eRd; logic [15:0] eDat; logic [15:0] eBusy;
  } vec_t;

  // Reference model: pending writes in order, plus the issuing output stage.
  ent_t        mq[$];
  logic        mWr;
  logic [3:0]  mRd;
  logic [15:0] mData;
  logic [15:0] mRf [16];
  logic [15:0] dRf [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] modelBusy();
    logic [15:0] b = '0;
    foreach (mq[i]) b[mq[i].dest] = 1'b1;
    if (mWr) b[mRd] = 1'b1;
    return b;
  endfunction

  task automatic drive(input logic mv, input logic [3:0] md, input logic [15:0] mdat,
                       input logic av, input logic [3:0] ad, input logic [15:0] adat,
                       input logic wb, input logic fl);
    memValid = mv; memDest = md; memData = mdat;
    aluValid = av; aluDest = ad; aluData = adat;
    wbEnable = wb; flush = fl;
  endtask

  task automatic modelCycle(input logic mv, input logic [3:0] md, input logic [15:0] mdat,
                            input logic av, input logic [3:0] ad, input logic [15:0] adat,
                            input logic wb, input logic fl);
    logic        eMr, eAr;
    logic [15:0] b;
    ent_t        e;
    drive(mv, md, mdat, av, ad, adat, wb, fl);
    qRs = 4'($urandom);
    qRt = 4'($urandom);
    eMr = !fl && (mq.size() < DEPTH);
    eAr = !fl && (mq.size() < DEPTH - 1);
    b   = modelBusy();
    #1;
    check("rnd memReady", memReady, eMr);
    check("rnd aluReady", aluReady, eAr);
    check("rnd rsBusy", rsBusy, b[qRs]);
    check("rnd rtBusy", rtBusy, b[qRt]);
    @(posedge clk);
    if (fl) begin
      mq.delete();
      mWr = 1'b0;
    end else begin
      if (wb && mq.size() > 0) begin
        e = mq.pop_front();
        mWr = 1'b1; mRd = e.dest; mData = e.data;
      end else begin
        mWr = 1'b0;
      end
      if (mv && eMr) mq.push_back('{dest: md, data: mdat});
      if (av && eAr) mq.push_back('{dest: ad, data: adat});
    end
    #1;
    check("rnd rfRegWrite", rfRegWrite, mWr);
    check("rnd rfRd", rfRd, mRd);
    check("rnd rfWriteData", rfWriteData, mData);
    check("rnd busyVec", busyVec, modelBusy());
    if (rfRegWrite) dRf[rfRd] = rfWriteData;
    if (mWr) mRf[mRd] = mData;
  endtask

  vec_t vecs [14];

  initial begin
    int writes;

    vecs[0]  = '{1'b0, 4'd0, 16'h0, 1'b1, 4'd3, 16'h1234, 1'b1, 1'b0, 1'b1, 1'b1,
                 1'b0, 4'd0, 16'h0000, 16'h0008};
    vecs[1]  = '{1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, 1'b1, 1'b0, 1'b1, 1'b1,
                 1'b1, 4'd3, 16'h1234, 16'h0008};
    vecs[2]  = '{1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, 1'b1, 1'b0, 1'b1, 1'b1,
                 1'b0, 4'd3, 16'h1234, 16'h0000};
    vecs[3]  = '{1'b1, 4'd5, 16'hAAAA, 1'b1, 4'd5, 16'h5555, 1'b1, 1'b0, 1'b1, 1'b1,
                 1'b0, 4'd3, 16'h1234, 16'h0020};
    vecs[4]  = '{1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, 1'b1, 1'b0, 1'b1, 1'b1,
                 1'b1, 4'd5, 16'hAAAA, 16'h0020};
    vecs[5]  = '{1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, 1'b1, 1'b0, 1'b1, 1'b1,
                 1'b1, 4'd5, 16'h5555, 16'h0020};
    vecs[6]  = '{1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, 1'b1, 1'b0, 1'b1, 1'b1,
                 1'b0, 4'd5, 16'h5555, 16'h0000};
    vecs[7]  = '{1'b1, 4'd1, 16'h0001, 1'b1, 4'd2, 16'h0002, 1'b0, 1'b0, 1'b1, 1'b1,
                 1'b0, 4'd5, 16'h5555, 16'h0006};
    vecs[8]  = '{1'b0, 4'd0, 16'h0, 1'b1, 4'd4, 16'h0004, 1'b0, 1'b0, 1'b1, 1'b1,
                 1'b0, 4'd5, 16'h5555, 16'h0016};
    vecs[9]  = '{1'b1, 4'd7, 16'h0007, 1'b1, 4'd6, 16'h0006, 1'b0, 1'b0, 1'b1, 1'b0,
                 1'b0, 4'd5, 16'h5555, 16'h0096};
    vecs[10] = '{1'b1, 4'd8, 16'h0008, 1'b1, 4'd9, 16'h0009, 1'b0, 1'b0, 1'b0, 1'b0,
                 1'b0, 4'd5, 16'h5555, 16'h0096};
    vecs[11] = '{1'b1, 4'd8, 16'h0008, 1'b0, 4'd0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0,
                 1'b1, 4'd1, 16'h0001, 16'h0096};
    vecs[12] = '{1'b1, 4'd10, 16'h000A, 1'b0, 4'd0, 16'h0, 1'b1, 1'b1, 1'b0, 1'b0,
                 1'b0, 4'd1, 16'h0001, 16'h0000};
    vecs[13] = '{1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, 1'b1, 1'b0, 1'b1, 1'b1,
                 1'b0, 4'd1, 16'h0001, 16'h0000};

    for (int r = 0; r < 16; r++) begin
      mRf[r] = '0;
      dRf[r] = '0;
    end
    reset = 1'b1;
    qRs = '0;
    qRt = '0;
    drive(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, 1'b0, 1'b0);
    #2;
    check("reset rfRegWrite", rfRegWrite, 1'b0);
    check("reset rfRd", rfRd, 4'd0);
    check("reset rfWriteData", rfWriteData, 16'h0);
    check("reset busyVec", busyVec, 16'h0);
    check("reset memReady", memReady, 1'b1);
    check("reset aluReady", aluReady, 1'b1);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Directed table: single write, same-register pair, fill to full, flush.
    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].mv, vecs[i].md, vecs[i].mdat, vecs[i].av, vecs[i].ad, vecs[i].adat,
            vecs[i].wb, vecs[i].fl);
      #1;
      check($sformatf("v%0d memReady", i), memReady, vecs[i].eMr);
      check($sformatf("v%0d aluReady", i), aluReady, vecs[i].eAr);
      @(posedge clk);
      #1;
      check($sformatf("v%0d rfRegWrite", i), rfRegWrite, vecs[i].eWr);
      check($sformatf("v%0d rfRd", i), rfRd, vecs[i].eRd);
      check($sformatf("v%0d rfWriteData", i), rfWriteData, vecs[i].eDat);
      check($sformatf("v%0d busyVec", i), busyVec, vecs[i].eBusy);
    end

    // Asynchronous reset while a write issues and another is queued.
    drive(1'b1, 4'd11, 16'hBBBB, 1'b1, 4'd12, 16'hCCCC, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    drive(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    check("prereset rfRegWrite", rfRegWrite, 1'b1);
    check("prereset rfRd", rfRd, 4'd11);
    #2;
    reset = 1'b1;
    #1;
    check("async reset rfRegWrite", rfRegWrite, 1'b0);
    check("async reset rfRd", rfRd, 4'd0);
    check("async reset rfWriteData", rfWriteData, 16'h0);
    check("async reset busyVec", busyVec, 16'h0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    writes = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (rfRegWrite) writes++;
    end
    check("no write after reset", writes, 0);

    // Random traffic against the reference model, starting from the empty post-reset state.
    mq.delete();
    mWr = 1'b0;
    mRd = '0;
    mData = '0;
    for (int c = 0; c < 3000; c++) begin
      modelCycle(1'($urandom % 2), 4'($urandom), 16'($urandom),
                 1'($urandom % 2), 4'($urandom), 16'($urandom),
                 1'(($urandom % 4) != 0), 1'(($urandom % 32) == 0));
    end
    repeat (DEPTH + 3) modelCycle(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, 1'b1, 1'b0);
    for (int r = 0; r < 16; r++) check($sformatf("regfile r%0d", r), dRf[r], mRf[r]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
